// File: rtl/counter_snapshot_cdc_fifo.sv
// Free-running counter in clk_19_3 whose upper field is snapshotted into a gray-pointer
// asynchronous FIFO and presented in clk_4_5. Optional: define OVERFLOW_CNT_EN for drop_count.
module counter_snapshot_cdc_fifo #(
    parameter int CNT_W     = 30,
    parameter int SNAP_LOG2 = 24,
    parameter int OUT_W     = CNT_W - SNAP_LOG2,
    parameter int ADDR_W    = 3
) (
    input  logic             clk_19_3,
    input  logic             reset_button,
    input  logic             clk_4_5,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [OUT_W-1:0] rd_data,
    output logic             wr_full
`ifdef OVERFLOW_CNT_EN
    ,
    output logic [15:0]      drop_count
`endif
);

    localparam int               DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]  PTR_ZERO = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W - 1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] OUT_ZERO = {OUT_W{1'b0}};
    localparam logic [OUT_W-1:0] OUT_ONE  = {{(OUT_W - 1){1'b0}}, 1'b1};

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] bin);
        return bin ^ {1'b0, bin[ADDR_W:1]};
    endfunction

    // ------------------------------------------------------------------
    // Write domain (clk_19_3)
    // ------------------------------------------------------------------
    logic [1:0]        wrst_sync_q;
    logic              wrst_n_s;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W:0]   wbin_q;
    logic [ADDR_W:0]   wbin_d;
    logic [ADDR_W:0]   wgray_q;
    logic [ADDR_W:0]   wgray_d;
    logic              wr_full_q;
    logic              wr_full_d;
    logic [ADDR_W:0]   rgray_s1_q;
    logic [ADDR_W:0]   rgray_s2_q;
    logic              push_s;
    logic              wr_en_s;
    logic [OUT_W-1:0]  push_data_s;
    logic [OUT_W-1:0]  mem_q [DEPTH];

    // Write-domain reset: asserts immediately, releases after two clk_19_3 edges
    always_ff @(posedge clk_19_3 or negedge reset_button) begin
        if (!reset_button) begin
            wrst_sync_q <= 2'b00;
        end else begin
            wrst_sync_q <= {wrst_sync_q[0], 1'b1};
        end
    end

    assign wrst_n_s = wrst_sync_q[1];

    // Counter step, push decision and full prediction for the next pointer value
    always_comb begin
        cnt_d       = cnt_q + CNT_ONE;
        push_s      = &cnt_q[SNAP_LOG2-1:0];
        push_data_s = cnt_q[CNT_W-1:SNAP_LOG2] + OUT_ONE;
        wr_en_s     = push_s && !wr_full_q;
        if (wr_en_s) begin
            wbin_d = wbin_q + PTR_ONE;
        end else begin
            wbin_d = wbin_q;
        end
        wgray_d   = bin2gray(wbin_d);
        // Full when the write pointer is one lap ahead of the synchronised read pointer
        wr_full_d = (wgray_d == {~rgray_s2_q[ADDR_W:ADDR_W-1], rgray_s2_q[ADDR_W-2:0]});
    end

    // Write-domain state: counter, pointers, full flag and read-pointer synchroniser
    always_ff @(posedge clk_19_3 or negedge wrst_n_s) begin
        if (!wrst_n_s) begin
            cnt_q      <= CNT_ZERO;
            wbin_q     <= PTR_ZERO;
            wgray_q    <= PTR_ZERO;
            wr_full_q  <= 1'b0;
            rgray_s1_q <= PTR_ZERO;
            rgray_s2_q <= PTR_ZERO;
        end else begin
            cnt_q      <= cnt_d;
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            wr_full_q  <= wr_full_d;
            rgray_s1_q <= rgray_q;
            rgray_s2_q <= rgray_s1_q;
        end
    end

    // FIFO storage, written only from the write domain
    always_ff @(posedge clk_19_3) begin
        if (wr_en_s) begin
            mem_q[wbin_q[ADDR_W-1:0]] <= push_data_s;
        end
    end

    assign wr_full = wr_full_q;

`ifdef OVERFLOW_CNT_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of snapshots discarded while full
    always_ff @(posedge clk_19_3 or negedge wrst_n_s) begin
        if (!wrst_n_s) begin
            drop_cnt_q <= 16'h0000;
        end else if (push_s && wr_full_q && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'h0001;
        end else begin
            drop_cnt_q <= drop_cnt_q;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    // Without the overflow counter, snapshots arriving while full vanish silently.
`endif

    // ------------------------------------------------------------------
    // Read domain (clk_4_5)
    // ------------------------------------------------------------------
    logic [1:0]        rrst_sync_q;
    logic              rrst_n_s;
    logic [ADDR_W:0]   rbin_q;
    logic [ADDR_W:0]   rbin_d;
    logic [ADDR_W:0]   rgray_q;
    logic [ADDR_W:0]   rgray_d;
    logic [ADDR_W:0]   wgray_s1_q;
    logic [ADDR_W:0]   wgray_s2_q;
    logic              rd_valid_q;
    logic              rd_valid_d;
    logic [OUT_W-1:0]  rd_data_q;
    logic [OUT_W-1:0]  rd_data_d;
    logic              pop_s;
    logic              empty_s;

    // Read-domain reset: asserts immediately, releases after two clk_4_5 edges
    always_ff @(posedge clk_4_5 or negedge reset_button) begin
        if (!reset_button) begin
            rrst_sync_q <= 2'b00;
        end else begin
            rrst_sync_q <= {rrst_sync_q[0], 1'b1};
        end
    end

    assign rrst_n_s = rrst_sync_q[1];

    // Pop handling and first-word fall-through prefetch of the next head entry
    always_comb begin
        pop_s = rd_valid_q && rd_ready;
        if (pop_s) begin
            rbin_d = rbin_q + PTR_ONE;
        end else begin
            rbin_d = rbin_q;
        end
        rgray_d    = bin2gray(rbin_d);
        empty_s    = (rgray_d == wgray_s2_q);
        rd_valid_d = !empty_s;
        if (empty_s) begin
            rd_data_d = rd_data_q;
        end else begin
            rd_data_d = mem_q[rbin_d[ADDR_W-1:0]];
        end
    end

    // Read-domain state: pointers, output register and write-pointer synchroniser
    always_ff @(posedge clk_4_5 or negedge rrst_n_s) begin
        if (!rrst_n_s) begin
            rbin_q     <= PTR_ZERO;
            rgray_q    <= PTR_ZERO;
            wgray_s1_q <= PTR_ZERO;
            wgray_s2_q <= PTR_ZERO;
            rd_valid_q <= 1'b0;
            rd_data_q  <= OUT_ZERO;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            wgray_s1_q <= wgray_q;
            wgray_s2_q <= wgray_s1_q;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_counter_snapshot_cdc_fifo.sv
// Scoreboard bench for counter_snapshot_cdc_fifo with a reduced counter (CNT_W=10, SNAP_LOG2=4).
module tb_counter_snapshot_cdc_fifo;

    logic       clk_19_3 = 1'b0;
    logic       clk_4_5  = 1'b0;
    logic       reset_button;
    logic       rd_ready;
    logic       rd_valid;
    logic [5:0] rd_data;
    logic       wr_full;
`ifdef OVERFLOW_CNT_EN
    logic [15:0] drop_count;
`endif

    counter_snapshot_cdc_fifo #(
        .CNT_W     (10),
        .SNAP_LOG2 (4),
        .OUT_W     (6),
        .ADDR_W    (3)
    ) dut (
        .clk_19_3     (clk_19_3),
        .reset_button (reset_button),
        .clk_4_5      (clk_4_5),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .wr_full      (wr_full)
`ifdef OVERFLOW_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #26  clk_19_3 = ~clk_19_3;
    always #111 clk_4_5  = ~clk_4_5;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         wcyc    = 0;
    int         n_acc   = 0;
    int         n_pop   = 0;
    int         n_wrap  = 0;
    logic [5:0] exp_q[$];
    logic [5:0] last_val;
    logic       have_last;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic wait_wcyc(input int n);
        while (wcyc < n) @(negedge clk_19_3);
        #10;
    endtask

    // Expected-value producer: attempt j (j>=1) lands on write cycle 16*j+2 after release
    always @(posedge clk_19_3 or negedge reset_button) begin
        if (!reset_button) begin
            wcyc  <= 0;
            n_acc <= 0;
            exp_q.delete();
        end else begin
            wcyc <= wcyc + 1;
            if (wcyc >= 17 && ((wcyc - 1) % 16) == 0) begin
                if (n_acc - n_pop < 8) begin
                    exp_q.push_back(6'((wcyc - 1) / 16));
                    n_acc <= n_acc + 1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted handshake
    always @(negedge clk_4_5) begin
        #5;
        if (!reset_button) begin
            n_pop     = 0;
            have_last = 1'b0;
        end else if (rd_valid && rd_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow: actual=data %0d required=no output", rd_data);
            end else begin
                check("rd_data_order", rd_data, exp_q.pop_front());
            end
            if (have_last && last_val == 6'd63 && rd_data == 6'd0) n_wrap++;
            last_val  = rd_data;
            have_last = 1'b1;
        end
    end

    logic [3:0] p_wgray, p_wbin, p_rgray, p_rbin;
    logic       p_full, p_valid;

    // Write-side pointer properties: one gray bit per step, no advance while full
    always @(negedge clk_19_3) begin
        #2;
        if (reset_button) begin
            check("wgray_one_bit_step", int'($countones(dut.wgray_q ^ p_wgray) <= 1), 1);
            check("no_push_while_full", int'(p_full && (dut.wbin_q != p_wbin)), 0);
        end
        p_wgray = dut.wgray_q;
        p_wbin  = dut.wbin_q;
        p_full  = wr_full;
    end

    // Read-side pointer properties: one gray bit per step, no advance while empty
    always @(negedge clk_4_5) begin
        #3;
        if (reset_button) begin
            check("rgray_one_bit_step", int'($countones(dut.rgray_q ^ p_rgray) <= 1), 1);
            check("no_pop_while_empty", int'(!p_valid && (dut.rbin_q != p_rbin)), 0);
        end
        p_rgray = dut.rgray_q;
        p_rbin  = dut.rbin_q;
        p_valid = rd_valid;
    end

    initial begin
        reset_button = 1'b0;
        rd_ready     = 1'b1;
        p_wgray = 4'd0; p_wbin = 4'd0; p_rgray = 4'd0; p_rbin = 4'd0;
        p_full  = 1'b0; p_valid = 1'b0;
        last_val = 6'd0; have_last = 1'b0;
        repeat (5) @(negedge clk_4_5);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_wr_full", wr_full, 0);
`ifdef OVERFLOW_CNT_EN
        check("reset_drop_count", drop_count, 0);
`endif
        @(negedge clk_19_3) reset_button = 1'b1;

        // Streaming with consumer always ready: values 1..10
        wait_wcyc(177);
        check("p1_queue_drained", exp_q.size(), 0);
        check("p1_pop_count", n_pop, 10);

        // Stall consumer from reset: fill to full, drops, then drain 1..8 and resume at 13
        @(negedge clk_19_3) begin reset_button = 1'b0; rd_ready = 1'b0; end
        #1000;
        @(negedge clk_19_3) reset_button = 1'b1;
        wait_wcyc(120);
        check("p2_not_full_after_7", wr_full, 0);
        wait_wcyc(140);
        check("p2_full_after_8", wr_full, 1);
        wait_wcyc(190);
        check("p2_stall_valid", rd_valid, 1);
        check("p2_stall_data_holds_1", rd_data, 1);
        wait_wcyc(196);
        check("p2_still_full", wr_full, 1);
`ifdef OVERFLOW_CNT_EN
        check("p3_drop_count_4", drop_count, 4);
`endif
        @(negedge clk_4_5) rd_ready = 1'b1;

        // Continue through the 6-bit field wrap (attempt 64 carries 0)
        wait_wcyc(1137);
        check("p4_queue_drained", exp_q.size(), 0);
        check("p4_pop_count", n_pop, 66);
        check("p4_wrap_seen_once", n_wrap, 1);

        // Fill again, then reset mid-stream while full
        @(negedge clk_4_5) rd_ready = 1'b0;
        wait_wcyc(1313);
        check("p5_full_before_reset", wr_full, 1);
        reset_button = 1'b0;
        #1;
        check("p5_reset_rd_valid", rd_valid, 0);
        check("p5_reset_wr_full", wr_full, 0);
        check("p5_reset_rd_data", rd_data, 0);
        rd_ready = 1'b1;
        #1000;
        @(negedge clk_19_3) reset_button = 1'b1;
        wait_wcyc(97);
        check("p5_queue_drained", exp_q.size(), 0);
        check("p5_restart_pop_count", n_pop, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
